// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage pipeline: operand forwarding selects plus an
// FSM that sequences load-use stalls, branch flushes and debug halt/single-step.
module hazard_sequencer #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS4_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RS4_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             halt_req,
  input  logic             step_req,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       ForwardCE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             ForwardCD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [2:0] {RUN, LOAD_STALL, FLUSH, HALT, STEP} state_t;

  localparam logic [2:0] LS_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state, nextState, exitState;
  logic [2:0] cnt, nextCnt;
  logic       lu, br;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Memory stage result is newer than Writeback, so it wins when both match.
  function automatic logic [1:0] fwdSelE(input logic [4:0] rs, input logic wrM,
                                         input logic [4:0] rdM, input logic wrW,
                                         input logic [4:0] rdW);
    if (wrM && rdM != 5'd0 && rdM == rs)
      return 2'b10;
    else if (wrW && rdW != 5'd0 && rdW == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic fwdSelD(input logic [4:0] rs, input logic wrW,
                                   input logic [4:0] rdW);
    return wrW && rdW != 5'd0 && rdW == rs;
  endfunction

  always_comb begin
    ForwardAE = fwdSelE(RS1_E, RegWriteM, RD_M, RegWriteW, RD_W);
    ForwardBE = fwdSelE(RS2_E, RegWriteM, RD_M, RegWriteW, RD_W);
    ForwardCE = fwdSelE(RS4_E, RegWriteM, RD_M, RegWriteW, RD_W);
    ForwardAD = fwdSelD(RS1_D, RegWriteW, RD_W);
    ForwardBD = fwdSelD(RS2_D, RegWriteW, RD_W);
    ForwardCD = fwdSelD(RS4_D, RegWriteW, RD_W);

    lu = ResultSrcE && RD_E != 5'd0 &&
         (RD_E == RS1_D || RD_E == RS2_D || RD_E == RS4_D);
    br = PCSrcE;

    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    nextState = state;
    nextCnt   = cnt;
    exitState = halt_req ? HALT : RUN;

    case (state)
      RUN, STEP: begin
        if (br) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            nextState = FLUSH;
            nextCnt   = FL_INIT;
          end else if (state == STEP) begin
            nextState = exitState;
          end
        end else if (lu) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            nextState = LOAD_STALL;
            nextCnt   = LS_INIT;
          end else if (state == STEP) begin
            nextState = exitState;
          end
        end else if (halt_req && state == RUN) begin
          StallF    = 1'b1;
          StallD    = 1'b1;
          FlushE    = 1'b1;
          nextState = HALT;
        end else if (state == STEP) begin
          nextState = exitState;
        end
      end
      LOAD_STALL: begin
        if (br) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            nextState = FLUSH;
            nextCnt   = FL_INIT;
          end else begin
            nextState = exitState;
          end
        end else begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          if (cnt <= 3'd1) nextState = exitState;
          else             nextCnt   = cnt - 3'd1;
        end
      end
      FLUSH: begin
        FlushD = 1'b1;
        if (cnt <= 3'd1) nextState = exitState;
        else             nextCnt   = cnt - 3'd1;
      end
      HALT: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        if (!halt_req)     nextState = RUN;
        else if (step_req) nextState = STEP;
      end
      default: nextState = RUN;
    endcase

    if (!rst) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardCE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      ForwardCD = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= 3'd0;
      halted       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state  <= nextState;
      cnt    <= nextCnt;
      halted <= (nextState == HALT);
      if (StallD) stall_cycles <= satInc(stall_cycles);
    end
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central hazard controller for the 5-stage 18-bit pipeline. It generates the forwarding selects for the Decode and Execute stages and sequences load-use stalls and branch/jump flushes through a small FSM. It also implements a debug halt/single-step handshake and keeps a saturating stall-cycle counter. The block sits beside decode_cycle and drives its ForwardAD/BD/CD inputs plus the fetch/decode/execute stall and flush controls.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 1, cycles FlushD is held after a taken branch/jump (1..7)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
RS1_D, RS2_D, RS4_D  in  5 each  source register addresses in Decode
RS1_E, RS2_E, RS4_E  in  5 each  source register addresses in Execute
RD_E, RD_M, RD_W  in  5 each  destination register in Execute, Memory and Writeback
RegWriteM, RegWriteW  in  1 each  register-write enable in Memory and Writeback
ResultSrcE  in  1  1 = the instruction in Execute is a load
PCSrcE  in  1  taken branch or jump resolved in Execute
halt_req  in  1  debug halt request, level-sensitive
step_req  in  1  single-step pulse, valid only while halted
ForwardAE, ForwardBE, ForwardCE  out  2 each  Execute operand select: 00 register file, 01 Writeback, 10 Memory
ForwardAD, ForwardBD, ForwardCD  out  1 each  Decode bypass of ResultW
StallF, StallD, FlushD, FlushE  out  1 each  pipeline control
halted  out  1  pipeline is parked in HALT
stall_cycles  out  CNT_W  number of cycles in which StallD was high, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low. While rst=0 at a rising edge: state<=RUN, counter<=0, stall_cycles<=0, halted<=0. All combinational outputs are forced to 0 while rst=0.
- Register x0 is never a forwarding or hazard source. Any match against address 0 is ignored.
- Forwarding is combinational and independent of FSM state:
  - ForwardXE=10 if RegWriteM && RD_M!=0 && RD_M==RSx_E.
  - Otherwise ForwardXE=01 if RegWriteW && RD_W!=0 && RD_W==RSx_E.
  - Otherwise ForwardXE=00. Memory has priority over Writeback.
  - ForwardXD=1 iff RegWriteW && RD_W!=0 && RD_W==RSx_D.
- Hazard terms:
  - lu = ResultSrcE && RD_E!=0 && RD_E matches any of RS1_D, RS2_D, RS4_D.
  - br = PCSrcE.
- FSM states: RUN, LOAD_STALL, FLUSH, HALT, STEP. A 3-bit counter cnt tracks remaining cycles.
- RUN and STEP (identical hazard handling):
  - br: FlushD=FlushE=1 in the same cycle. br has priority over lu, so lu is ignored.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - Else if lu: StallF=StallD=FlushE=1 in the same cycle. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
  - Else if halt_req and state==RUN: StallF=StallD=FlushE=1 and go to HALT.
  - STEP with no multi-cycle hazard returns to HALT if halt_req, else to RUN.
- LOAD_STALL: StallF=StallD=FlushE=1. br still overrides and goes to the flush sequence.
- FLUSH: FlushD=1.
- LOAD_STALL and FLUSH decrement cnt each cycle. When cnt==1, exit to HALT if halt_req, else RUN.
- HALT:
  - halted=1 (registered: 1 from the first cycle in HALT). StallF=StallD=FlushE=1.
  - halt_req=0 goes to RUN.
  - step_req=1 goes to STEP. Exactly one instruction advances.
  - If both halt_req=0 and step_req=1, go to RUN.
- halted returns to 0 on the cycle the FSM leaves HALT for STEP or RUN.
- stall_cycles increments on every cycle with StallD=1 and saturates at all-ones.
- Reset asserted mid-sequence aborts any stall, flush or halt on that edge.

Test Plan:
- RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1, RS1_E=5 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set RD_M=RD_W=0, RS1_E=0 -> 00.
- Load-use: ResultSrcE=1, RD_E=7, RS2_D=7, LOAD_STALL_CYCLES=2 -> StallF/StallD/FlushE high for exactly 2 cycles, then RUN. stall_cycles=2.
- Same cycle PCSrcE=1 and load-use -> FlushD=FlushE=1, StallD=0. With FLUSH_CYCLES=3, FlushD is high for 3 cycles.
- halt_req=1 in RUN -> StallD=1 immediately, halted=1 on the next cycle. One step_req pulse -> exactly one cycle with StallD=0, then halted=1 again.
- rst=0 during the second cycle of a LOAD_STALL -> state RUN, all outputs 0 after the edge, stall_cycles=0.
- Force stall_cycles to 16'hFFFE, hold halt -> counter stops at 16'hFFFF.
